// File: rtl/serial_adder_ctrl_pkg.sv
// rtl/serial_adder_ctrl_pkg.sv - shared FSM state encoding for the serial adder controller
package serial_adder_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// rtl/serial_adder_ctrl_full_adder.sv - combinational 1-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and carry of three single-bit inputs
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer with push-button start and LED status
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pmod,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done,
    output logic [1:0]       led
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             s1;
    logic             s2;
    logic             prev;
    logic             start_pulse;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             led_valid;
    logic             fa_s;
    logic             fa_c;

    // Falling edge of the synchronised (active-low) button; flops reset to "released"
    assign start_pulse = prev & ~s2;
    assign led         = {led_valid, (state != ST_IDLE)};

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, run WIDTH cycles, one DONE cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_pulse) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == CNT_LAST) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Button synchroniser, shifters, counter, carry and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= 1'b1;
            s2        <= 1'b1;
            prev      <= 1'b1;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            done      <= 1'b0;
            led_valid <= 1'b0;
        end else begin
            s1   <= pmod;
            s2   <= s1;
            prev <= s2;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_pulse) begin
                        a_sh      <= a_in;
                        b_sh      <= b_in;
                        carry     <= 1'b0;
                        cnt       <= '0;
                        sum_sh    <= '0;
                        led_valid <= 1'b0;
                    end
                end
                ST_RUN: begin
                    sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_c;
                    cnt    <= cnt + CW'(1);
                end
                ST_DONE: begin
                    sum       <= sum_sh;
                    cout      <= carry;
                    done      <= 1'b1;
                    led_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - randomized self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             pmod;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             done;
    logic [1:0]       led;

    int n_tests;
    int n_fail;
    int n_done;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .pmod (pmod),
        .a_in (a_in),
        .b_in (b_in),
        .sum  (sum),
        .cout (cout),
        .done (done),
        .led  (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done) n_done++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full add: press, hold for 'hold' cycles, optional mid-run disturbance
    task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int hold, input bit disturb);
        logic [WIDTH:0] exp_res;
        int cyc;
        int pc;
        int nd0;
        bit seen;
        exp_res = {1'b0, a} + {1'b0, b};
        nd0  = n_done;
        a_in = a;
        b_in = b;
        pmod = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 10 && !seen) begin
            @(negedge clk);
            cyc++;
            if (led[0]) seen = 1'b1;
        end
        check("accept_latency", cyc, 3);
        check("led_running", {30'd0, led}, 2'b01);
        pc   = cyc;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 40 && !seen) begin
            if (pc >= hold) pmod = 1'b1;
            if (disturb) begin
                if (cyc == 2) a_in = ~a;
                if (cyc == 4) pmod = 1'b0;
            end
            @(negedge clk);
            cyc++;
            pc++;
            if (done) seen = 1'b1;
        end
        check("done_latency", cyc, WIDTH + 1);
        check("sum", {24'd0, sum}, {24'd0, exp_res[WIDTH-1:0]});
        check("cout", {31'd0, cout}, {31'd0, exp_res[WIDTH]});
        while (pc < hold) begin
            @(negedge clk);
            pc++;
        end
        pmod = 1'b1;
        repeat (5) @(negedge clk);
        check("done_count", n_done - nd0, 1);
        check("led_idle_valid", {30'd0, led}, 2'b10);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        n_done  = 0;
        rst  = 1'b1;
        pmod = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(negedge clk);
        check("rst_sum", {24'd0, sum}, 0);
        check("rst_cout", {31'd0, cout}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_led", {30'd0, led}, 0);
        pmod = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("no_start_after_rst", {30'd0, led}, 0);
        check("no_done_after_rst", n_done, 0);

        do_add(8'h3C, 8'h5A, 1, 1'b0);
        do_add(8'hFF, 8'h01, 2, 1'b0);
        do_add(8'hFF, 8'hFF, 3, 1'b0);
        do_add(8'h00, 8'h00, 3, 1'b0);
        do_add(8'h81, 8'h7E, 3, 1'b1);
        do_add(8'hA5, 8'hC3, 50, 1'b0);

        // Reset in the middle of a run
        begin
            int nd0;
            nd0  = n_done;
            a_in = 8'h12;
            b_in = 8'h34;
            pmod = 1'b0;
            repeat (3) @(negedge clk);
            pmod = 1'b1;
            check("mid_rst_running", {30'd0, led}, 2'b01);
            repeat (4) @(negedge clk);
            rst = 1'b1;
            #1;
            check("mid_rst_sum", {24'd0, sum}, 0);
            check("mid_rst_cout", {31'd0, cout}, 0);
            check("mid_rst_led", {30'd0, led}, 0);
            @(negedge clk);
            rst = 1'b0;
            repeat (20) @(negedge clk);
            check("mid_rst_no_done", n_done - nd0, 0);
            check("mid_rst_led_after", {30'd0, led}, 0);
        end

        for (int i = 0; i < 256; i++) begin
            do_add(WIDTH'($urandom), WIDTH'($urandom), 1 + int'($urandom_range(0, 4)),
                   1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
